rtc_bcd_stopwatch_gen: RTL and testbench

RTC_BCD_STOPWATCH_GEN -- requirements
Module: rtc_bcd_stopwatch_gen

---
 rtl/rtc_bcd_stopwatch_gen.sv | 118 +++++++++++
 tb/tb_rtc_bcd_stopwatch_gen.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/rtc_bcd_stopwatch_gen.sv
// BCD stopwatch / real-time counter with a hundredths-of-a-second resolution.
// Digit layout (MSB..LSB): [TH,H,] TM,M,TS,S,HMS,TMS, one BCD nibble each.
// A prescaler turns PRESCALE input clocks into one 10 ms count step; the
// count runs up or down, can be preset, and can capture lap values.
module rtc_bcd_stopwatch_gen #(
  parameter int PRESCALE = 2,
  parameter int HOURS_EN = 0
) (
  input  logic                       i_rtcclk,
  input  logic                       i_reset,
  input  logic                       i_countenb,
  input  logic                       i_countinit,
  input  logic [24+8*HOURS_EN-1:0]   i_preset,
  input  logic                       i_down,
  input  logic                       i_latchcount,
  output logic [24+8*HOURS_EN-1:0]   o_count,
  output logic [24+8*HOURS_EN-1:0]   o_latched,
  output logic                       o_latch_valid,
  output logic                       o_tc
);

  localparam int W    = 24 + 8 * HOURS_EN;
  localparam int NDIG = W / 4;
  localparam int PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  // Largest legal value of the digit at position idx (0 = TMS).
  // Tens-of-seconds and tens-of-minutes roll over at 5, all others at 9.
  function automatic logic [3:0] digit_max(input int idx);
    return (idx == 3 || idx == 5) ? 4'd5 : 4'd9;
  endfunction

  logic [PW-1:0] prescale_cnt;
  logic [W-1:0]  inc_val;
  logic [W-1:0]  dec_val;
  logic [W-1:0]  load_val;
  logic          inc_c;
  logic          dec_b;
  logic          inc_wrap;
  logic          at_zero;
  logic          step;

  assign step    = i_countenb && (prescale_cnt == PRE_LAST);
  assign at_zero = (o_count == '0);

  // Ripple-carry increment, ripple-borrow decrement and clamped preset,
  // computed for every digit in parallel so a step updates all at once.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write, so
    // no path leaves a value unassigned and no latch is inferred.
    inc_val  = '0;
    dec_val  = '0;
    load_val = '0;
    inc_c    = 1'b1;
    dec_b    = 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      if (inc_c && (o_count[4*i +: 4] >= digit_max(i))) begin
        inc_val[4*i +: 4] = 4'd0;
      end else begin
        inc_val[4*i +: 4] = o_count[4*i +: 4] + {3'b000, inc_c};
        inc_c = 1'b0;
      end
      if (dec_b && (o_count[4*i +: 4] == 4'd0)) begin
        dec_val[4*i +: 4] = digit_max(i);
      end else begin
        dec_val[4*i +: 4] = o_count[4*i +: 4] - {3'b000, dec_b};
        dec_b = 1'b0;
      end
      load_val[4*i +: 4] = (i_preset[4*i +: 4] > digit_max(i)) ? digit_max(i)
                                                                : i_preset[4*i +: 4];
    end
    // A carry surviving past the top digit means the count was at full scale.
    inc_wrap = inc_c;
  end

  // Count, prescaler and terminal-count pulse; preset load beats a step.
  always_ff @(posedge i_rtcclk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (i_reset) begin
      o_count      <= '0;
      prescale_cnt <= '0;
      o_tc         <= 1'b0;
    end else begin
      o_tc <= 1'b0;
      if (i_countinit) begin
        o_count      <= load_val;
        prescale_cnt <= '0;
      end else if (i_countenb) begin
        if (step) begin
          prescale_cnt <= '0;
          if (!i_down) begin
            o_count <= inc_val;
            o_tc    <= inc_wrap;
          end else if (!at_zero) begin
            // Counting down stops at zero; only the step that lands there pulses.
            o_count <= dec_val;
            o_tc    <= (dec_val == '0);
          end
        end else begin
          prescale_cnt <= prescale_cnt + PW'(1);
        end
      end
    end
  end

  // Lap capture of the pre-update count, independent of enable and preset.
  always_ff @(posedge i_rtcclk) begin
    if (i_reset) begin
      o_latched     <= '0;
      o_latch_valid <= 1'b0;
    end else if (i_latchcount) begin
      o_latched     <= o_count;
      o_latch_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rtc_bcd_stopwatch_gen.sv
// Scoreboard bench for rtc_bcd_stopwatch_gen (PRESCALE=2, hours enabled).
// The reference model keeps the time as a plain number of hundredths of a
// second and converts to/from BCD digits only at the boundaries.
module tb_rtc_bcd_stopwatch_gen;

  localparam int PRESCALE = 2;
  localparam int HOURS_EN = 1;
  localparam int W        = 24 + 8 * HOURS_EN;
  localparam int FULL     = (HOURS_EN != 0) ? 100 * 360000 : 360000;

  typedef struct packed {
    logic [W-1:0] count;
    logic [W-1:0] latched;
    logic         valid;
    logic         tc;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         enb;
  logic         init;
  logic [W-1:0] preset;
  logic         down;
  logic         latch;
  logic [W-1:0] count;
  logic [W-1:0] latched;
  logic         latch_valid;
  logic         tc;

  rtc_bcd_stopwatch_gen #(.PRESCALE(PRESCALE), .HOURS_EN(HOURS_EN)) dut (
    .i_rtcclk      (clk),
    .i_reset       (rst),
    .i_countenb    (enb),
    .i_countinit   (init),
    .i_preset      (preset),
    .i_down        (down),
    .i_latchcount  (latch),
    .o_count       (count),
    .o_latched     (latched),
    .o_latch_valid (latch_valid),
    .o_tc          (tc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state.
  int           m_total;
  int           m_pre;
  logic [W-1:0] m_lat;
  logic         m_valid;
  logic         m_tc;

  exp_t sb_q[$];
  int   vectors;
  int   miscompares;
  exp_t mon_e;

  function automatic logic [W-1:0] to_bcd(input int t);
    int cs, s, m, h;
    logic [W-1:0] r;
    cs = t % 100;
    s  = (t / 100) % 60;
    m  = (t / 6000) % 60;
    h  = t / 360000;
    r  = '0;
    r[3:0]   = 4'(cs % 10);
    r[7:4]   = 4'(cs / 10);
    r[11:8]  = 4'(s % 10);
    r[15:12] = 4'(s / 10);
    r[19:16] = 4'(m % 10);
    r[23:20] = 4'(m / 10);
    if (HOURS_EN != 0) r[W-1:24] = 8'({4'(h / 10), 4'(h % 10)});
    return r;
  endfunction

  function automatic int preset_total(input logic [W-1:0] p);
    int d[8];
    for (int i = 0; i < 8; i++) begin
      d[i] = (i < W / 4) ? int'(p[4*i +: 4]) : 0;
      if (i == 3 || i == 5) begin
        if (d[i] > 5) d[i] = 5;
      end else if (d[i] > 9) begin
        d[i] = 9;
      end
    end
    return (d[0] + 10 * d[1]) + 100 * (d[2] + 10 * d[3]) +
           6000 * (d[4] + 10 * d[5]) + 360000 * (d[6] + 10 * d[7]);
  endfunction

  // Apply one cycle of stimulus; the model predicts the post-edge outputs.
  task automatic drive(input logic r, input logic e, input logic ci,
                       input logic [W-1:0] p, input logic d, input logic l);
    exp_t x;
    rst = r; enb = e; init = ci; preset = p; down = d; latch = l;
    if (r) begin
      m_total = 0; m_pre = 0; m_lat = '0; m_valid = 1'b0; m_tc = 1'b0;
    end else begin
      m_tc = 1'b0;
      if (l) begin
        m_lat   = to_bcd(m_total);
        m_valid = 1'b1;
      end
      if (ci) begin
        m_total = preset_total(p);
        m_pre   = 0;
      end else if (e) begin
        if (m_pre == PRESCALE - 1) begin
          m_pre = 0;
          if (!d) begin
            m_total = (m_total + 1) % FULL;
            m_tc    = (m_total == 0);
          end else if (m_total != 0) begin
            m_total = m_total - 1;
            m_tc    = (m_total == 0);
          end
        end else begin
          m_pre = m_pre + 1;
        end
      end
    end
    x.count   = to_bcd(m_total);
    x.latched = m_lat;
    x.valid   = m_valid;
    x.tc      = m_tc;
    sb_q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, input logic d);
    repeat (n) drive(1'b0, 1'b1, 1'b0, '0, d, 1'b0);
  endtask

  task automatic load(input logic [W-1:0] p, input logic d);
    drive(1'b0, 1'b0, 1'b1, p, d, 1'b0);
  endtask

  // Monitor: compares each post-edge output set against the oldest prediction.
  always @(posedge clk) begin
    #2;
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      vectors++;
      if (count !== mon_e.count || latched !== mon_e.latched ||
          latch_valid !== mon_e.valid || tc !== mon_e.tc) begin
        miscompares++;
        $display("FAIL outputs @%0t: count=%h latched=%h valid=%b tc=%b, expected count=%h latched=%h valid=%b tc=%b",
                 $time, count, latched, latch_valid, tc,
                 mon_e.count, mon_e.latched, mon_e.valid, mon_e.tc);
      end
    end
  end

  initial begin
    logic [W-1:0] p;
    vectors     = 0;
    miscompares = 0;
    m_total = 0; m_pre = 0; m_lat = '0; m_valid = 1'b0; m_tc = 1'b0;

    // Reset, then 20 enabled up cycles: 10 steps -> 00000010, no tc.
    repeat (2) drive(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    run(20, 1'b0);
    // Full-scale wrap with tc, then minute/hour carry.
    load(32'h99595999, 1'b0);
    run(3, 1'b0);
    load(32'h00595999, 1'b0);
    run(2, 1'b0);
    // Down to zero with one tc, then held at zero.
    load(32'h00000002, 1'b1);
    run(8, 1'b1);
    load(32'h00010000, 1'b1);
    run(2, 1'b1);
    // Direction change mid-period.
    load(32'h00000050, 1'b0);
    run(3, 1'b0);
    run(3, 1'b1);
    // Lap capture together with a clamped preset load.
    load(32'h00001230, 1'b0);
    run(8, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 32'h007F00AA, 1'b0, 1'b1);
    run(2, 1'b0);
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    // Reset on the edge where a wrapping step would occur.
    load(32'h99595999, 1'b0);
    run(1, 1'b0);
    drive(1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b1);
    run(4, 1'b0);

    // Randomised traffic, biased toward the wrap and zero boundaries.
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 3))
        0:       p = W'($urandom);
        1:       p = 32'h99595999;
        2:       p = 32'h00000001;
        default: p = 32'h99595998;
      endcase
      drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 19) == 0), p, ($urandom_range(0, 1) == 1),
            ($urandom_range(0, 7) == 0));
    end

    repeat (2) @(posedge clk);
    #3;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d predictions left unchecked, expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
